// File: rtl/residual_encoder.sv
// -----------------------------------------------------------------------------
// residual_encoder
//
// Purpose:
//   Turns a stream of signed 16-bit prediction residuals into the FLAC
//   partitioned-Rice residual section. The section is emitted MSB-first:
//     - a 2-bit coding method (00)
//     - a 4-bit partition order
//     - then, for each partition, a 4-bit Rice parameter followed by that
//       partition's Rice-coded samples.
//   The bitstream is packed into 16-bit words and written to frame RAM from
//   address 0 upward.
//
// Ports:
//   iClock, iReset      clock; synchronous active-high reset
//   iStart              one-cycle pulse; latches iNSamples/iPredOrder/iPartOrder
//   iNSamples           frame blocksize
//   iPredOrder          predictor order (warm-up samples are not coded here)
//   iPartOrder          partition order, 2^po partitions
//   oParamReq           waiting for the current partition's Rice parameter
//   iParamValid         parameter accepted when oParamReq && iParamValid
//   iRiceParam          Rice parameter; escape (15) is clamped to 14
//   iResidual, iValid   signed residual; accepted when iValid && oReady
//   oReady              residual accept (pure state decode)
//   oWriteData          packed RAM word
//   oWriteAddr          RAM word address
//   oWriteEn            write strobe, one cycle per word
//   oWordCount          words in the section, valid with oDone
//   oDone               one-cycle pulse after the final padded word is written
// -----------------------------------------------------------------------------
module residual_encoder (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [15:0] iNSamples,
    input  logic [3:0]  iPredOrder,
    input  logic [3:0]  iPartOrder,
    output logic        oParamReq,
    input  logic        iParamValid,
    input  logic [3:0]  iRiceParam,
    input  logic [15:0] iResidual,
    input  logic        iValid,
    output logic        oReady,
    output logic [15:0] oWriteData,
    output logic [15:0] oWriteAddr,
    output logic        oWriteEn,
    output logic [15:0] oWordCount,
    output logic        oDone
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PARAM, S_SAMPLE, S_UNARY, S_BIN, S_FLUSH, S_DONE
    } state_t;

    state_t r_state, w_next;

    // Section configuration and per-partition bookkeeping
    logic [15:0] r_n;
    logic [3:0]  r_order;
    logic [3:0]  r_po;
    logic [3:0]  r_k;
    logic [15:0] r_part_idx;
    logic [15:0] r_part_rem;
    logic [15:0] r_u;
    logic [15:0] r_q;

    // Bit packer: pending bits left-aligned in r_acc, r_fill < 16 between cycles
    logic [31:0] r_acc;
    logic [4:0]  r_fill;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_waddr;
    logic        r_wen;
    logic [15:0] r_wcount;
    logic        r_done;

    logic [3:0]  w_k_in;
    logic [15:0] w_part_base;
    logic [15:0] w_part_size;
    logic        w_last_part;
    logic [15:0] w_fold;
    logic [15:0] w_q_in;
    logic [4:0]  w_q_chunk;
    logic [15:0] w_bin_bits;
    logic        w_part_done;
    logic [4:0]  w_push_n;
    logic [15:0] w_push_bits;
    logic [5:0]  w_total;
    logic [5:0]  w_shift;
    logic [31:0] w_merged;

    assign w_k_in      = (iRiceParam == 4'd15) ? 4'd14 : iRiceParam;
    assign w_last_part = (r_part_idx == ((16'd1 << r_po) - 16'd1));
    assign w_part_base = r_n >> r_po;
    // The predictor warm-up samples are carried outside this section, so the
    // first partition is short by the predictor order.
    assign w_part_size = (r_part_idx == 16'd0) ? (w_part_base - {12'd0, r_order})
                                                : w_part_base;
    // Zig-zag fold: 0,-1,1,-2,... -> 0,1,2,3,...
    assign w_fold      = {iResidual[14:0], 1'b0} ^ {16{iResidual[15]}};
    assign w_q_in      = w_fold >> r_k;
    assign w_q_chunk   = (r_q > 16'd16) ? 5'd16 : r_q[4:0];
    assign w_bin_bits  = (16'd1 << r_k) | (r_u & ((16'd1 << r_k) - 16'd1));
    assign w_part_done = (r_part_rem == 16'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register
            // samples pre-edge values; blocking here would create order races.
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (iStart) w_next = S_HDR;
            S_HDR:    w_next = S_PARAM;
            S_PARAM: begin
                if (iParamValid) begin
                    if (w_part_size != 16'd0) w_next = S_SAMPLE;
                    else if (w_last_part)     w_next = S_FLUSH;
                    else                      w_next = S_PARAM;
                end
            end
            S_SAMPLE: if (iValid) w_next = (w_q_in != 16'd0) ? S_UNARY : S_BIN;
            S_UNARY:  if (r_q <= 16'd16) w_next = S_BIN;
            S_BIN: begin
                if (!w_part_done)     w_next = S_SAMPLE;
                else if (w_last_part) w_next = S_FLUSH;
                else                  w_next = S_PARAM;
            end
            S_FLUSH:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: output decode (handshakes and bit pushes) ----------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; a missing default would infer a latch.
        oParamReq   = 1'b0;
        oReady      = 1'b0;
        w_push_n    = 5'd0;
        w_push_bits = 16'd0;
        case (r_state)
            S_HDR: begin
                w_push_n    = 5'd6;
                w_push_bits = {12'd0, r_po};
            end
            S_PARAM: begin
                oParamReq = 1'b1;
                if (iParamValid) begin
                    w_push_n    = 5'd4;
                    w_push_bits = {12'd0, w_k_in};
                end
            end
            S_SAMPLE: oReady = 1'b1;
            S_UNARY:  w_push_n = w_q_chunk;
            S_BIN: begin
                w_push_n    = {1'b0, r_k} + 5'd1;
                w_push_bits = w_bin_bits;
            end
            S_FLUSH:  if (r_fill != 5'd0) w_push_n = 5'd16 - r_fill;
            default: ;
        endcase
    end

    // ---------------- Section / partition datapath ----------------
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_n        <= 16'd0;
            r_order    <= 4'd0;
            r_po       <= 4'd0;
            r_k        <= 4'd0;
            r_part_idx <= 16'd0;
            r_part_rem <= 16'd0;
            r_u        <= 16'd0;
            r_q        <= 16'd0;
            r_wcount   <= 16'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_n        <= iNSamples;
                        r_order    <= iPredOrder;
                        r_po       <= iPartOrder;
                        r_part_idx <= 16'd0;
                    end
                end
                S_PARAM: begin
                    if (iParamValid) begin
                        r_k        <= w_k_in;
                        r_part_rem <= w_part_size;
                        if (w_part_size == 16'd0) r_part_idx <= r_part_idx + 16'd1;
                    end
                end
                S_SAMPLE: begin
                    if (iValid) begin
                        r_u <= w_fold;
                        r_q <= w_q_in;
                    end
                end
                S_UNARY: r_q <= r_q - {11'd0, w_q_chunk};
                S_BIN: begin
                    r_part_rem <= r_part_rem - 16'd1;
                    if (w_part_done) r_part_idx <= r_part_idx + 16'd1;
                end
                S_DONE: begin
                    // The flush write has already advanced r_addr
                    r_wcount <= r_addr;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Bit packer ----------------
    assign w_total  = {1'b0, r_fill} + {1'b0, w_push_n};
    // Place the n new bits directly below the pending ones
    assign w_shift  = 6'd32 - w_total;
    assign w_merged = r_acc | ({16'd0, w_push_bits} << w_shift);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_acc   <= 32'd0;
            r_fill  <= 5'd0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_waddr <= 16'd0;
            r_wen   <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (r_state == S_IDLE && iStart) begin
                r_acc  <= 32'd0;
                r_fill <= 5'd0;
                r_addr <= 16'd0;
            end else if (w_total >= 6'd16) begin
                r_wdata <= w_merged[31:16];
                r_wen   <= 1'b1;
                r_waddr <= r_addr;
                r_addr  <= r_addr + 16'd1;
                r_acc   <= w_merged << 16;
                r_fill  <= w_total[4:0] - 5'd16;
            end else begin
                r_acc  <= w_merged;
                r_fill <= w_total[4:0];
            end
        end
    end

    assign oWriteData = r_wdata;
    assign oWriteAddr = r_waddr;
    assign oWriteEn   = r_wen;
    assign oWordCount = r_wcount;
    assign oDone      = r_done;

endmodule

// File: tb/tb_residual_encoder.sv
// -----------------------------------------------------------------------------
// tb_residual_encoder
//
// Table-driven bench for residual_encoder: each record holds the section
// configuration, the parameters and residuals to feed, and the hand-derived
// packed words. Extra hand-written sequences cover the long unary run and an
// abort by reset in the middle of a unary run.
// -----------------------------------------------------------------------------
module tb_residual_encoder;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iStart;
    logic [15:0] iNSamples;
    logic [3:0]  iPredOrder;
    logic [3:0]  iPartOrder;
    logic        oParamReq;
    logic        iParamValid;
    logic [3:0]  iRiceParam;
    logic [15:0] iResidual;
    logic        iValid;
    logic        oReady;
    logic [15:0] oWriteData;
    logic [15:0] oWriteAddr;
    logic        oWriteEn;
    logic [15:0] oWordCount;
    logic        oDone;

    always #5 iClock = ~iClock;

    residual_encoder dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iStart      (iStart),
        .iNSamples   (iNSamples),
        .iPredOrder  (iPredOrder),
        .iPartOrder  (iPartOrder),
        .oParamReq   (oParamReq),
        .iParamValid (iParamValid),
        .iRiceParam  (iRiceParam),
        .iResidual   (iResidual),
        .iValid      (iValid),
        .oReady      (oReady),
        .oWriteData  (oWriteData),
        .oWriteAddr  (oWriteAddr),
        .oWriteEn    (oWriteEn),
        .oWordCount  (oWordCount),
        .oDone       (oDone)
    );

    typedef logic [3:0]  par_arr_t  [4];
    typedef logic [15:0] res_arr_t  [8];
    typedef logic [15:0] word_arr_t [4];

    typedef struct {
        logic [15:0] n;
        logic [3:0]  order;
        logic [3:0]  po;
        int          np;
        par_arr_t    params;
        int          nr;
        res_arr_t    res;
        int          nw;
        word_arr_t   words;
        bit          b2b;     // first two parameters must be accepted on consecutive cycles
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_pass   = 0;

    // Results captured by run_section
    logic [15:0] wq_addr [$];
    logic [15:0] wq_data [$];
    int          p_cyc   [$];
    bit          got_done;
    int          got_wc;
    int          p_cnt;
    int          r_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else
            n_pass++;
    endtask

    // Starts a section and services the parameter / residual handshakes until
    // oDone or the cycle budget runs out. Inputs change on the falling edge.
    task automatic run_section(input string tag, input logic [15:0] n, input logic [3:0] order,
                               input logic [3:0] po, input int np, input par_arr_t params,
                               input int nr, input res_arr_t res, input int budget);
        int cyc;
        wq_addr.delete();
        wq_data.delete();
        p_cyc.delete();
        got_done = 1'b0;
        got_wc   = 0;
        p_cnt    = 0;
        r_cnt    = 0;
        @(negedge iClock);
        iStart     = 1'b1;
        iNSamples  = n;
        iPredOrder = order;
        iPartOrder = po;
        @(negedge iClock);
        iStart = 1'b0;
        cyc    = 0;
        while (!got_done && cyc < budget) begin
            if (oWriteEn) begin
                wq_addr.push_back(oWriteAddr);
                wq_data.push_back(oWriteData);
            end
            if (oDone) begin
                got_done = 1'b1;
                got_wc   = oWordCount;
            end
            iParamValid = (p_cnt < np);
            iRiceParam  = (p_cnt < np) ? params[p_cnt] : 4'd0;
            iValid      = (r_cnt < nr);
            iResidual   = (r_cnt < nr) ? res[r_cnt] : 16'd0;
            if (iParamValid && oParamReq) begin
                p_cyc.push_back(cyc);
                p_cnt++;
            end
            if (iValid && oReady) r_cnt++;
            @(negedge iClock);
            cyc++;
        end
        iParamValid = 1'b0;
        iValid      = 1'b0;
        check({tag, " done"}, got_done, 1'b1);
    endtask

    initial begin
        int bad_data;
        int bad_addr;
        int wen_seen;
        par_arr_t p_big;
        res_arr_t r_big;

        iReset      = 1'b1;
        iStart      = 1'b0;
        iNSamples   = 16'd0;
        iPredOrder  = 4'd0;
        iPartOrder  = 4'd0;
        iParamValid = 1'b0;
        iRiceParam  = 4'd0;
        iResidual   = 16'd0;
        iValid      = 1'b0;

        repeat (3) @(negedge iClock);
        check("reset oParamReq",  oParamReq,  1'b0);
        check("reset oReady",     oReady,     1'b0);
        check("reset oWriteEn",   oWriteEn,   1'b0);
        check("reset oWriteData", oWriteData, 16'd0);
        check("reset oWriteAddr", oWriteAddr, 16'd0);
        check("reset oWordCount", oWordCount, 16'd0);
        check("reset oDone",      oDone,      1'b0);
        iReset = 1'b0;

        // v0: N=4 order=3 po=0 k=2, r=+3 -> 000000 0010 0 1 10 + 2 pad
        vecs[0].n = 16'd4; vecs[0].order = 4'd3; vecs[0].po = 4'd0;
        vecs[0].np = 1; vecs[0].params = '{4'd2, 4'd0, 4'd0, 4'd0};
        vecs[0].nr = 1; vecs[0].res = '{16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[0].nw = 1; vecs[0].words = '{16'h0098, 16'd0, 16'd0, 16'd0};
        vecs[0].b2b = 1'b0;

        // v1: N=4 order=2 po=0 k=0, r=-1,0 -> 000000 0000 01 1 + 3 pad (MSB-aligned)
        vecs[1].n = 16'd4; vecs[1].order = 4'd2; vecs[1].po = 4'd0;
        vecs[1].np = 1; vecs[1].params = '{4'd0, 4'd0, 4'd0, 4'd0};
        vecs[1].nr = 2; vecs[1].res = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[1].nw = 1; vecs[1].words = '{16'h0018, 16'd0, 16'd0, 16'd0};
        vecs[1].b2b = 1'b0;

        // v2: N=8 order=2 po=1, k=1 over {2,-3}, k=3 over {0,7,-8,20}
        //     000001 0001 0010 0011 0011 1000 01110 01111 000001000 + 3 pad
        vecs[2].n = 16'd8; vecs[2].order = 4'd2; vecs[2].po = 4'd1;
        vecs[2].np = 2; vecs[2].params = '{4'd1, 4'd3, 4'd0, 4'd0};
        vecs[2].nr = 6; vecs[2].res = '{16'd2, 16'hFFFD, 16'd0, 16'd7, 16'hFFF8, 16'd20, 16'd0, 16'd0};
        vecs[2].nw = 3; vecs[2].words = '{16'h0448, 16'hCE1C, 16'hF040, 16'd0};
        vecs[2].b2b = 1'b0;

        // v3: N=4 order=2 po=1 -> partition 0 empty; second param 15 clamps to 14
        //     000001 0101 1110 1 00000000000010 1 00000000000011 + 4 pad
        vecs[3].n = 16'd4; vecs[3].order = 4'd2; vecs[3].po = 4'd1;
        vecs[3].np = 2; vecs[3].params = '{4'd5, 4'd15, 4'd0, 4'd0};
        vecs[3].nr = 2; vecs[3].res = '{16'd1, 16'hFFFE, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[3].nw = 3; vecs[3].words = '{16'h057A, 16'h0014, 16'h0030, 16'd0};
        vecs[3].b2b = 1'b1;

        // v4: exactly 16 bits, flush needs no padding: 000000 0000 111111
        vecs[4].n = 16'd6; vecs[4].order = 4'd0; vecs[4].po = 4'd0;
        vecs[4].np = 1; vecs[4].params = '{4'd0, 4'd0, 4'd0, 4'd0};
        vecs[4].nr = 6; vecs[4].res = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[4].nw = 1; vecs[4].words = '{16'h003F, 16'd0, 16'd0, 16'd0};
        vecs[4].b2b = 1'b0;

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            run_section(tag, vecs[i].n, vecs[i].order, vecs[i].po, vecs[i].np, vecs[i].params,
                        vecs[i].nr, vecs[i].res, 300);
            check({tag, " params taken"},    p_cnt,          vecs[i].np);
            check({tag, " residuals taken"}, r_cnt,          vecs[i].nr);
            check({tag, " write count"},     wq_data.size(), vecs[i].nw);
            check({tag, " oWordCount"},      got_wc,         vecs[i].nw);
            for (int j = 0; j < vecs[i].nw && j < wq_data.size(); j++) begin
                check($sformatf("%s word%0d addr", tag, j), wq_addr[j], j);
                check($sformatf("%s word%0d data", tag, j), wq_data[j], vecs[i].words[j]);
            end
            if (vecs[i].b2b && p_cyc.size() >= 2)
                check({tag, " params back-to-back"}, p_cyc[1] - p_cyc[0], 1);
        end

        // Worst case: r=-32768, k=0 -> 65535 zeros then a 1
        p_big = '{4'd0, 4'd0, 4'd0, 4'd0};
        r_big = '{16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        run_section("big", 16'd1, 4'd0, 4'd0, 1, p_big, 1, r_big, 6000);
        check("big write count", wq_data.size(), 4097);
        check("big oWordCount",  got_wc,         4097);
        bad_data = 0;
        bad_addr = 0;
        for (int j = 0; j < 4096 && j < wq_data.size(); j++) begin
            if (wq_data[j] !== 16'h0000) bad_data++;
            if (wq_addr[j] !== j[15:0])  bad_addr++;
        end
        check("big zero words", bad_data, 0);
        check("big addresses",  bad_addr, 0);
        if (wq_data.size() >= 4097) begin
            check("big last data", wq_data[4096], 16'h0040);
            check("big last addr", wq_addr[4096], 16'd4096);
        end

        // Reset in the middle of a long unary run
        @(negedge iClock);
        iStart = 1'b1; iNSamples = 16'd1; iPredOrder = 4'd0; iPartOrder = 4'd0;
        @(negedge iClock);
        iStart = 1'b0;
        iParamValid = 1'b1; iRiceParam = 4'd0;
        for (int i = 0; i < 10 && !oParamReq; i++) @(negedge iClock);
        check("abort param req", oParamReq, 1'b1);
        @(negedge iClock);
        iParamValid = 1'b0;
        iValid = 1'b1; iResidual = 16'h8000;
        for (int i = 0; i < 10 && !oReady; i++) @(negedge iClock);
        check("abort ready", oReady, 1'b1);
        @(negedge iClock);
        iValid = 1'b0;
        wen_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClock);
            if (oWriteEn) wen_seen++;
        end
        check("abort unary writing", wen_seen > 10, 1'b1);
        iReset = 1'b1;
        @(negedge iClock);
        check("abort oWriteEn",  oWriteEn,  1'b0);
        check("abort oReady",    oReady,    1'b0);
        check("abort oParamReq", oParamReq, 1'b0);
        check("abort oDone",     oDone,     1'b0);
        iReset = 1'b0;
        @(negedge iClock);
        check("abort idle after release", oWriteEn, 1'b0);

        // Restart after the abort must begin again at address 0
        run_section("restart", vecs[0].n, vecs[0].order, vecs[0].po, vecs[0].np, vecs[0].params,
                    vecs[0].nr, vecs[0].res, 300);
        check("restart write count", wq_data.size(), 1);
        if (wq_data.size() >= 1) begin
            check("restart addr", wq_addr[0], 16'd0);
            check("restart data", wq_data[0], 16'h0098);
        end
        check("restart oWordCount", got_wc, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
